// File: rtl/vscale_pc_gen_if.sv
// rtl/vscale_pc_gen_if.sv - instruction-memory fetch request port
interface vscale_pc_gen_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] PC_PIF;

    modport master (
        output imem_req_valid,
        output PC_PIF,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  PC_PIF,
        output imem_req_ready
    );
endinterface

// File: rtl/vscale_pc_gen.sv
// rtl/vscale_pc_gen.sv - fetch PC register and next-fetch-address selection
module vscale_pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h200),
    parameter int              CAUSE_W      = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          PC_src_sel,
    input  logic [31:0]         inst_DX,
    input  logic [XLEN-1:0]     PC_DX,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     csr_tvec,
    input  logic [XLEN-1:0]     csr_epc,
    input  logic                trap_is_int,
    input  logic [CAUSE_W-1:0]  trap_cause,
    input  logic                stall_IF,
    vscale_pc_gen_if.master     imem,
    output logic [XLEN-1:0]     PC_IF,
    output logic                redirect_pending,
    output logic                misaligned_target
);

    localparam logic [2:0] SEL_PLUS_FOUR = 3'd0;
    localparam logic [2:0] SEL_JAL       = 3'd1;
    localparam logic [2:0] SEL_REG       = 3'd2;
    localparam logic [2:0] SEL_BRANCH    = 3'd3;
    localparam logic [2:0] SEL_REPLAY    = 3'd4;
    localparam logic [2:0] SEL_TVEC      = 3'd5;
    localparam logic [2:0] SEL_EPC       = 3'd6;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_if_q;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_imm;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] reg_target;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_target;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] computed_pc;
    logic [XLEN-1:0] pc_pif;
    logic            redir_req;
    logic            align_checked;
    logic            misalign_raw;
    logic            redirect;
    logic            req_valid;
    logic            adv;

    logic unused_bits;
    assign unused_bits = &{1'b0, inst_DX[24:12], inst_DX[6:0], rs1_data[0], csr_tvec[1]};

    assign pc_plus4      = pc_if_q + XLEN'(4);
    assign branch_imm    = {{(XLEN-13){inst_DX[31]}}, inst_DX[31], inst_DX[7],
                            inst_DX[30:25], inst_DX[11:8], 1'b0};
    assign branch_target = PC_DX + branch_imm;
    assign reg_target    = {rs1_data[XLEN-1:1], 1'b0};
    assign tvec_base     = {csr_tvec[XLEN-1:2], 2'b00};
    // Vectored mode only offsets interrupts; synchronous exceptions use the base.
    assign tvec_target   = (csr_tvec[0] && trap_is_int)
                         ? tvec_base + (XLEN'(trap_cause) << 2)
                         : tvec_base;

    always_comb begin
        redir_target  = pc_plus4;
        redir_req     = 1'b0;
        align_checked = 1'b0;
        case (PC_src_sel)
            SEL_JAL: begin
                redir_target  = alu_out;
                redir_req     = 1'b1;
                align_checked = 1'b1;
            end
            SEL_REG: begin
                redir_target  = reg_target;
                redir_req     = 1'b1;
                align_checked = 1'b1;
            end
            SEL_BRANCH: begin
                redir_target  = branch_target;
                redir_req     = 1'b1;
                align_checked = 1'b1;
            end
            SEL_TVEC: begin
                redir_target = tvec_target;
                redir_req    = 1'b1;
            end
            SEL_EPC: begin
                redir_target = csr_epc;
                redir_req    = 1'b1;
            end
            default: begin
                redir_target = pc_plus4;
            end
        endcase
    end

    // A misaligned jump/branch target is dropped and fetch simply falls through.
    assign misalign_raw = align_checked && (redir_target[1:0] != 2'b00);
    assign redirect     = redir_req && !misalign_raw;
    assign seq_target   = (PC_src_sel == SEL_REPLAY) ? pc_if_q : pc_plus4;
    assign computed_pc  = redirect ? redir_target : seq_target;

    assign req_valid = reset_n;
    assign adv       = req_valid && imem.imem_req_ready && !stall_IF;

    always_comb begin
        state_d          = state_q;
        pend_pc_d        = pend_pc_q;
        pc_pif           = computed_pc;
        redirect_pending = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_pif = RESET_VECTOR;
                if (adv) state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_pif = computed_pc;
                if (redirect && !adv) begin
                    pend_pc_d = redir_target;
                    state_d   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                redirect_pending = 1'b1;
                // Newest redirect wins and is presented in the same cycle.
                if (redirect) begin
                    pc_pif    = redir_target;
                    pend_pc_d = redir_target;
                end else begin
                    pc_pif = pend_pc_q;
                end
                if (adv) state_d = ST_RUN;
            end
            default: begin
                pc_pif  = RESET_VECTOR;
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_BOOT;
            pc_if_q   <= RESET_VECTOR;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            if (adv) pc_if_q <= pc_pif;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.PC_PIF         = pc_pif;
    assign PC_IF               = pc_if_q;
    assign misaligned_target   = reset_n && (state_q != ST_BOOT) && misalign_raw;

endmodule

// File: tb/tb_vscale_pc_gen.sv
// tb/tb_vscale_pc_gen.sv - directed bench for vscale_pc_gen
module tb_vscale_pc_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  PC_src_sel;
    logic [31:0] inst_DX;
    logic [31:0] PC_DX;
    logic [31:0] alu_out;
    logic [31:0] rs1_data;
    logic [31:0] csr_tvec;
    logic [31:0] csr_epc;
    logic        trap_is_int;
    logic [4:0]  trap_cause;
    logic        stall_IF;
    logic [31:0] PC_IF;
    logic        redirect_pending;
    logic        misaligned_target;

    int checks = 0;
    int passes = 0;

    vscale_pc_gen_if #(.XLEN(32)) imem_if ();

    vscale_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h200), .CAUSE_W(5)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .PC_src_sel        (PC_src_sel),
        .inst_DX           (inst_DX),
        .PC_DX             (PC_DX),
        .alu_out           (alu_out),
        .rs1_data          (rs1_data),
        .csr_tvec          (csr_tvec),
        .csr_epc           (csr_epc),
        .trap_is_int       (trap_is_int),
        .trap_cause        (trap_cause),
        .stall_IF          (stall_IF),
        .imem              (imem_if),
        .PC_IF             (PC_IF),
        .redirect_pending  (redirect_pending),
        .misaligned_target (misaligned_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; PC_src_sel = 3'd0; inst_DX = '0; PC_DX = '0; alu_out = '0;
        rs1_data = '0; csr_tvec = '0; csr_epc = '0; trap_is_int = 1'b0; trap_cause = '0;
        stall_IF = 1'b0; imem_if.imem_req_ready = 1'b1;
        step(); step();
        check("rst_valid", 32'(imem_if.imem_req_valid), 32'd0);
        check("rst_pif", imem_if.PC_PIF, 32'h200);
        check("rst_pcif", PC_IF, 32'h200);
        check("rst_pend", 32'(redirect_pending), 32'd0);
        check("rst_mis", 32'(misaligned_target), 32'd0);

        reset_n = 1'b1; #1;
        check("boot_valid", 32'(imem_if.imem_req_valid), 32'd1);
        check("boot_pif", imem_if.PC_PIF, 32'h200);
        step();
        check("seq_pcif0", PC_IF, 32'h200);
        check("seq_pif0", imem_if.PC_PIF, 32'h204);
        step();
        check("seq_pcif1", PC_IF, 32'h204);
        step();
        check("seq_pcif2", PC_IF, 32'h208);

        // branch imm = -8 from 0x1000
        PC_src_sel = 3'd3; PC_DX = 32'h1000; inst_DX = 32'hFE000CE3; #1;
        check("br_pif", imem_if.PC_PIF, 32'hFF8);
        check("br_mis", 32'(misaligned_target), 32'd0);
        step();
        check("br_pcif", PC_IF, 32'hFF8);

        PC_src_sel = 3'd1; alu_out = 32'h3000; imem_if.imem_req_ready = 1'b0; #1;
        check("jal_pif", imem_if.PC_PIF, 32'h3000);
        check("jal_nopend", 32'(redirect_pending), 32'd0);
        step();
        PC_src_sel = 3'd0; #1;
        check("pend1", 32'(redirect_pending), 32'd1);
        check("pend1_pif", imem_if.PC_PIF, 32'h3000);
        check("pend1_pcif", PC_IF, 32'hFF8);
        step();
        check("pend2_pif", imem_if.PC_PIF, 32'h3000);
        step();
        check("pend3_pif", imem_if.PC_PIF, 32'h3000);
        imem_if.imem_req_ready = 1'b1;
        step();
        check("pend_acc_pcif", PC_IF, 32'h3000);
        check("pend_acc_flag", 32'(redirect_pending), 32'd0);

        // trap replaces a held redirect
        PC_src_sel = 3'd1; alu_out = 32'h3000; imem_if.imem_req_ready = 1'b0;
        step();
        PC_src_sel = 3'd5; csr_tvec = 32'h101; trap_is_int = 1'b1; trap_cause = 5'd7; #1;
        check("tvec_vec", imem_if.PC_PIF, 32'h11C);
        step();
        PC_src_sel = 3'd0; #1;
        check("tvec_held", imem_if.PC_PIF, 32'h11C);
        check("tvec_pend", 32'(redirect_pending), 32'd1);
        PC_src_sel = 3'd5; trap_is_int = 1'b0; #1;
        check("tvec_exc", imem_if.PC_PIF, 32'h100);
        imem_if.imem_req_ready = 1'b1;
        step();
        PC_src_sel = 3'd0; #1;
        check("tvec_pcif", PC_IF, 32'h100);
        check("tvec_pif_next", imem_if.PC_PIF, 32'h104);

        PC_src_sel = 3'd2; rs1_data = 32'h2003; #1;
        check("reg_mis_flag", 32'(misaligned_target), 32'd1);
        check("reg_mis_pif", imem_if.PC_PIF, 32'h104);
        rs1_data = 32'h2001; #1;
        check("reg_ok_flag", 32'(misaligned_target), 32'd0);
        check("reg_ok_pif", imem_if.PC_PIF, 32'h2000);
        step();
        check("reg_pcif", PC_IF, 32'h2000);

        PC_src_sel = 3'd4; stall_IF = 1'b1; #1;
        check("replay_pif", imem_if.PC_PIF, 32'h2000);
        step();
        check("stall_pcif", PC_IF, 32'h2000);
        stall_IF = 1'b0; PC_src_sel = 3'd6; csr_epc = 32'h4444; #1;
        check("epc_pif", imem_if.PC_PIF, 32'h4444);

        PC_src_sel = 3'd1; alu_out = 32'hFFFF_FFFC;
        step();
        check("wrap_pre", PC_IF, 32'hFFFF_FFFC);
        PC_src_sel = 3'd0; #1;
        check("wrap_pif", imem_if.PC_PIF, 32'h0);
        step();
        check("wrap_pcif", PC_IF, 32'h0);

        PC_src_sel = 3'd1; alu_out = 32'h3000; imem_if.imem_req_ready = 1'b0;
        step();
        PC_src_sel = 3'd0; #1;
        check("rp_pend", 32'(redirect_pending), 32'd1);
        reset_n = 1'b0; #1;
        check("rp_valid", 32'(imem_if.imem_req_valid), 32'd0);
        check("rp_pcif", PC_IF, 32'h200);
        check("rp_pif", imem_if.PC_PIF, 32'h200);
        check("rp_flag", 32'(redirect_pending), 32'd0);
        step();
        reset_n = 1'b1; imem_if.imem_req_ready = 1'b1; #1;
        check("rp_boot_pif", imem_if.PC_PIF, 32'h200);
        step();
        check("rp_boot_pcif", PC_IF, 32'h200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
